mac_pipe: RTL and testbench
===========================

Name: mac_pipe

Overview:
- Pipelined, parametrised RISC-V M-extension multiply unit with an added signed multiply-accumulate mode for FFT butterfly kernels.
- Sits in the execute stage beside the ALU.
- Takes operands and a 5-bit op code through a valid/ready handshake and returns results in order after a fixed LATENCY.
- Holds one internal accumulator register.

Parameters:
- XLEN, 32, operand and result width (≥8).
- LATENCY, 2, cycles from input acceptance to out_valid (≥1). Stages 1..LATENCY-1 carry the product; stage LATENCY is the output register.
- ACC_W, 72, accumulator width (≥2*XLEN). Guard bits above 2*XLEN absorb overflow.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  unit can accept this cycle.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- ctrl  in  5  op code.
- out_valid  out  1  y holds a result.
- out_ready  in  1  consumer takes y this cycle.
- y  out  XLEN  result.
- acc_ovf  out  1  sticky: accumulator signed overflow past ACC_W.

Behaviour:
- Op codes:
  - 10 MUL: low XLEN of a*b.
  - 11 MULH: high XLEN of signed*signed.
  - 12 MULHU: high XLEN of unsigned*unsigned.
  - 13 MULHSU: high XLEN of signed a * unsigned b.
  - 16 MACC: acc += sext(signed a*b); y = new acc[XLEN-1:0].
  - 17 ACCLO: y = acc[XLEN-1:0].
  - 18 ACCHI: y = acc[2*XLEN-1:XLEN].
  - 19 ACCCLR: acc = 0, acc_ovf = 0, y = 0.
  - Any other code: y = 0, no side effect, still occupies a slot and returns a result.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. The whole pipe advances together or stalls together.
  - in_ready does not depend on in_valid.
- Pipeline:
  - Each stage has a valid bit.
  - Bubbles advance when the pipe advances. No bubble squeezing, so latency is exactly LATENCY cycles when unstalled.
  - Throughput is one op per cycle.
  - Stall: all stage registers hold; y and out_valid are stable until consumed.
- Accumulator:
  - Read and write only at the edge where an op enters the output stage, so ops commit in program order.
  - ACCLO/ACCHI/MACC see every earlier MACC/ACCCLR, including one directly ahead in the pipe (no hazard stalls).
  - MACC sum is computed at ACC_W bits and wraps.
  - acc_ovf is set when the sign of the true sum is not representable in ACC_W bits. It is cleared only by ACCCLR or rst.
- Product width:
  - Full 2*XLEN product per signedness mode.
  - MACC product is sign-extended to ACC_W.
- Reset:
  - rst clears all stage valid bits, out_valid = 0, y = 0, acc = 0, acc_ovf = 0.
  - In-flight ops are discarded; no output for them.
  - in_ready = 1 in the cycle after rst deasserts.
- rst while out_valid && !out_ready: result is dropped.
- Simultaneous output consume and input accept in the same cycle is legal and required for full throughput.

Test Plan:
- MUL/MULH/MULHU/MULHSU with a=32'hFFFFFFFF, b=32'h00000002 (out_ready=1) produce, LATENCY cycles after each accept, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF respectively.
- Back-to-back stream of 8 MUL ops (a=i, b=i+1) with out_ready=1 → one result per cycle, y=i*(i+1), in order, in_ready constantly 1.
- Backpressure: issue 3 ops, hold out_ready=0 for 5 cycles → in_ready=0 once out_valid=1, y stable; release → the 3 results appear in order, none lost or duplicated.
- Accumulate sequence:
  - ACCCLR, then MACC(3,4), then MACC(-2,5), then ACCLO, then ACCHI, all back-to-back.
  - y = 0, 12, 2, 2, 0.
  - Then MACC(32'h80000000,32'h80000000) twice → ACCHI returns 32'h80000000, acc_ovf stays 0.
- Overflow with ACC_W=64: repeat MACC(32'h7FFFFFFF,32'h7FFFFFFF) until the sum exceeds 2^63-1 → acc_ovf=1 and stays 1; ACCCLR clears it.
- Reset mid-stream: 2 ops in flight, assert rst one cycle → out_valid=0, y=0; no stale results afterwards; ACCLO after rst returns 0.

Source files
------------

// File: rtl/mac_pipe_if.sv
// Operand/result handshake bundle for mac_pipe.
// The master drives operands and out_ready; the slave (the unit) returns results.
interface mac_pipe_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      ctrl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] y;
   logic            acc_ovf;

   modport master (
      output in_valid, a, b, ctrl, out_ready,
      input  in_ready, out_valid, y, acc_ovf
   );

   modport slave (
      input  in_valid, a, b, ctrl, out_ready,
      output in_ready, out_valid, y, acc_ovf
   );
endinterface

// File: rtl/mac_pipe.sv
// Pipelined RISC-V M-extension multiplier with a signed multiply-accumulate mode.
// The whole pipe advances or stalls as one; the accumulator is touched only in the output stage.
module mac_pipe #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned ACC_W   = 72
) (
   input logic       clk,
   input logic       rst,
   mac_pipe_if.slave bus
);
   localparam int unsigned PW = 2 * XLEN;

   localparam logic [4:0] OpMul    = 5'd10;
   localparam logic [4:0] OpMulh   = 5'd11;
   localparam logic [4:0] OpMulhu  = 5'd12;
   localparam logic [4:0] OpMulhsu = 5'd13;
   localparam logic [4:0] OpMacc   = 5'd16;
   localparam logic [4:0] OpAccLo  = 5'd17;
   localparam logic [4:0] OpAccHi  = 5'd18;
   localparam logic [4:0] OpAccClr = 5'd19;

   logic             advance;
   logic             in_fire;
   logic             out_valid_q;
   logic [XLEN-1:0]  y_q, y_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   assign advance       = !out_valid_q || bus.out_ready;
   assign in_fire       = bus.in_valid && advance;
   assign bus.in_ready  = advance;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.acc_ovf   = ovf_q;

   logic          a_sgn, b_sgn;
   logic [PW-1:0] a_w, b_w, prod;

   // Extending both operands to 2*XLEN per signedness makes one multiplier serve every mode.
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (bus.ctrl)
         OpMulh, OpMacc: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         OpMulhsu: a_sgn = 1'b1;
         default: ;
      endcase
      a_w  = {{XLEN{a_sgn & bus.a[XLEN-1]}}, bus.a};
      b_w  = {{XLEN{b_sgn & bus.b[XLEN-1]}}, bus.b};
      prod = a_w * b_w;
   end

   logic          feed_valid;
   logic [4:0]    feed_op;
   logic [PW-1:0] feed_prod;

   generate
      if (LATENCY > 1) begin : g_stages
         localparam int unsigned NS = LATENCY - 1;
         logic [NS-1:0] v_q;
         logic [4:0]    op_q   [NS];
         logic [PW-1:0] prod_q [NS];

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= '0;
            end else if (advance) begin
               v_q[0] <= in_fire;
               for (int unsigned i = 1; i < NS; i++) v_q[i] <= v_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (advance) begin
               op_q[0]   <= bus.ctrl;
               prod_q[0] <= prod;
               for (int unsigned i = 1; i < NS; i++) begin
                  op_q[i]   <= op_q[i-1];
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign feed_valid = v_q[NS-1];
         assign feed_op    = op_q[NS-1];
         assign feed_prod  = prod_q[NS-1];
      end else begin : g_direct
         assign feed_valid = in_fire;
         assign feed_op    = bus.ctrl;
         assign feed_prod  = prod;
      end
   endgenerate

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]   sum;

   always_comb begin
      prod_ext = ACC_W'($signed(feed_prod));
      // One extra bit exposes signed overflow as a mismatch of the top two sum bits.
      sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
      y_d      = '0;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      case (feed_op)
         OpMul: y_d = feed_prod[XLEN-1:0];
         OpMulh, OpMulhu, OpMulhsu: y_d = feed_prod[PW-1:XLEN];
         OpMacc: begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | (sum[ACC_W] ^ sum[ACC_W-1]);
            y_d   = sum[XLEN-1:0];
         end
         OpAccLo: y_d = acc_q[XLEN-1:0];
         OpAccHi: y_d = acc_q[PW-1:XLEN];
         OpAccClr: begin
            acc_d = '0;
            ovf_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= feed_valid;
         if (feed_valid) begin
            y_q   <= y_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
         end
      end
   end
endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: a 72-bit and a 64-bit accumulator instance see identical stimulus.
module tb_mac_pipe;
   localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHU = 5'd12, MULHSU = 5'd13;
   localparam logic [4:0] MACC = 5'd16, ACCLO = 5'd17, ACCHI = 5'd18, ACCCLR = 5'd19;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  ctrl = '0;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] y;
      logic        o72;
      logic        o64;
   } exp_t;
   exp_t exp_q[$];

   mac_pipe_if #(.XLEN(32)) bus72 ();
   mac_pipe_if #(.XLEN(32)) bus64 ();

   assign bus72.in_valid  = in_valid;
   assign bus72.a         = a;
   assign bus72.b         = b;
   assign bus72.ctrl      = ctrl;
   assign bus72.out_ready = out_ready;
   assign bus64.in_valid  = in_valid;
   assign bus64.a         = a;
   assign bus64.b         = b;
   assign bus64.ctrl      = ctrl;
   assign bus64.out_ready = out_ready;

   mac_pipe #(.XLEN(32), .LATENCY(2), .ACC_W(72)) u_dut72 (.clk(clk), .rst(rst), .bus(bus72));
   mac_pipe #(.XLEN(32), .LATENCY(2), .ACC_W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   // Presents one op, records its expected result and waits (bounded) for acceptance.
   task automatic send(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ey, input logic eo72, input logic eo64);
      bit ok;
      int n;
      exp_q.push_back('{y: ey, o72: eo72, o64: eo64});
      in_valid = 1'b1;
      ctrl     = op;
      a        = av;
      b        = bv;
      ok       = 1'b0;
      n        = 0;
      while (!ok && n < 50) begin
         ok = bus72.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Result scoreboard: every consumed output must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus72.out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("y72", 64'(bus72.y), 64'(e.y));
            chk("y64", 64'(bus64.y), 64'(e.y));
            chk("ovf72", 64'(bus72.acc_ovf), 64'(e.o72));
            chk("ovf64", 64'(bus64.acc_ovf), 64'(e.o64));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(bus72.out_valid), 64'd0);
      chk("rst_y", 64'(bus72.y), 64'd0);
      chk("rst_ovf", 64'(bus72.acc_ovf), 64'd0);
      chk("rst_in_ready", 64'(bus72.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Multiply modes, first one with an explicit latency check
      send(MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_early", 64'(bus72.out_valid), 64'd0);
      @(negedge clk);
      chk("lat_on_time", 64'(bus72.out_valid), 64'd1);
      @(posedge clk);
      #1;
      send(MULH,   32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0);
      send(MULHU,  32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 1'b0, 1'b0);
      send(MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0);
      drain();

      // Back-to-back stream: one result per cycle, in_ready held high
      for (int i = 0; i < 8; i++) begin
         chk("stream_in_ready", 64'(bus72.in_ready), 64'd1);
         send(MUL, 32'(i), 32'(i + 1), 32'(i * (i + 1)), 1'b0, 1'b0);
      end
      drain();

      // Backpressure: third op held off while the output is stalled
      out_ready = 1'b0;
      send(MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
      send(MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
      exp_q.push_back('{y: 32'd81, o72: 1'b0, o64: 1'b0});
      in_valid = 1'b1;
      ctrl     = MUL;
      a        = 32'd9;
      b        = 32'd9;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus72.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus72.out_valid), 64'd1);
         chk("bp_y_stable", 64'(bus72.y), 64'd15);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

      // Accumulate sequence, back-to-back
      send(ACCCLR, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      send(MACC, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
      send(MACC, 32'hFFFF_FFFE, 32'd5, 32'd2, 1'b0, 1'b0);
      send(ACCLO, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0);
      send(ACCHI, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      // 2^62 twice: fits 72 bits, wraps the 64-bit accumulator
      send(MACC, 32'h8000_0000, 32'h8000_0000, 32'd2, 1'b0, 1'b0);
      send(MACC, 32'h8000_0000, 32'h8000_0000, 32'd2, 1'b0, 1'b1);
      send(ACCHI, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
      drain();

      // Overflow run: P = 0x3FFFFFFF_00000001, 3P exceeds 2^63-1
      send(ACCCLR, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      send(MACC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(MACC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd2, 1'b0, 1'b0);
      send(MACC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd3, 1'b0, 1'b1);
      send(MACC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd4, 1'b0, 1'b1);
      send(ACCHI, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
      send(ACCCLR, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      // Undefined op code: zero result, accumulator untouched
      send(5'd14, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
      send(ACCLO, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      send(MACC, 32'd7, 32'd7, 32'd49, 1'b0, 1'b0);
      drain();

      // Reset with two ops in flight
      out_ready = 1'b0;
      send(MUL, 32'd2, 32'd3, 32'd6, 1'b0, 1'b0);
      send(MUL, 32'd4, 32'd5, 32'd20, 1'b0, 1'b0);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(bus72.out_valid), 64'd0);
      chk("mid_rst_y", 64'(bus72.y), 64'd0);
      chk("mid_rst_in_ready", 64'(bus72.in_ready), 64'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(ACCLO, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
